// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the pipeline skid stage.
// The state encoding doubles as the occupancy count reported on the occupancy port.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: steps by one per enabled cycle and holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// One-cycle pipeline stage with a registered in_ready and an optional skid entry.
// Handshake: a beat moves on a rising edge when valid & ready are both high on that side.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = DATA_W'(RV_NOP),
    parameter int                SKID_EN     = 1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = (state_q != ST_EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            head_d  = NOP_PAYLOAD;
            skid_d  = NOP_PAYLOAD;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_MAIN;
                        head_d  = in_data;
                    end
                end
                ST_MAIN: begin
                    case ({in_fire, out_fire})
                        2'b11: head_d = in_data;
                        2'b01: begin
                            state_d = ST_EMPTY;
                            head_d  = NOP_PAYLOAD;
                        end
                        2'b10: begin
                            if (SKID_EN != 0) begin
                                state_d = ST_SKID;
                                skid_d  = in_data;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_MAIN;
                        head_d  = skid_q;
                        skid_d  = NOP_PAYLOAD;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    head_d  = NOP_PAYLOAD;
                    skid_d  = NOP_PAYLOAD;
                end
            endcase
        end
    end

    // in_ready is registered from the next state so it never depends on out_ready combinationally.
    always_comb begin
        in_ready_d = 1'b0;
        if (SKID_EN != 0) begin
            in_ready_d = (state_d != ST_SKID);
        end else begin
            in_ready_d = (state_d == ST_EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            head_q     <= NOP_PAYLOAD;
            skid_q     <= NOP_PAYLOAD;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (flush),
        .count(flush_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_q;
    assign occupancy = state_q;

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the payload width in bits (legal range 1..512).
REQ-002 Parameter NOP_PAYLOAD, default DATA_W'h00000013, SHALL be the payload driven while the stage holds a bubble.
REQ-003 Parameter SKID_EN, default 1, SHALL select the 2-entry skid mode (1) or the 1-entry stall-register mode (0).
REQ-004 Parameter CNT_W, default 16, SHALL set the width of flush_cnt.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-007 Port in_valid, input, 1, SHALL indicate that upstream offers in_data.
REQ-008 Port in_data, input, DATA_W, SHALL carry the upstream payload.
REQ-009 Port in_ready, output, 1, SHALL indicate the stage accepts in_data this cycle; it is driven directly from a flop.
REQ-010 Port out_valid, output, 1, SHALL indicate that out_data holds a real instruction payload.
REQ-011 Port out_data, output, DATA_W, SHALL carry the head payload, or NOP_PAYLOAD when out_valid=0.
REQ-012 Port out_ready, input, 1, SHALL indicate that downstream consumes out_data this cycle.
REQ-013 Port flush, input, 1, SHALL discard all held and incoming payloads.
REQ-014 Port occupancy, output, 2, SHALL report the number of held entries (0..2).
REQ-015 Port flush_cnt, output, CNT_W, SHALL hold a saturating count of cycles in which flush=1.

Function
REQ-016 A transfer SHALL occur on an input edge when in_valid & in_ready, and on an output edge when out_valid & out_ready.
REQ-017 Latency from an accepted input to its appearance at out_data/out_valid SHALL be exactly 1 cycle.
REQ-018 While out_ready is held at 1, the stage SHALL sustain 1 transfer per cycle with no bubbles.
REQ-019 The state machine SHALL have the states EMPTY (occupancy 0), MAIN (1) and SKID (2, SKID_EN=1 only).
REQ-020 EMPTY SHALL move to MAIN on an input transfer.
REQ-021 MAIN SHALL stay in MAIN on input and output transfers in the same cycle.
REQ-022 MAIN SHALL move to EMPTY on an output transfer without an input transfer.
REQ-023 MAIN SHALL move to SKID on an input transfer without an output transfer; the new payload goes to the skid entry.
REQ-024 SKID SHALL move to MAIN on an output transfer, with the skid entry promoted to the head.
REQ-025 In SKID, in_ready SHALL be 0.
REQ-026 In EMPTY and MAIN, in_ready SHALL be 1.
REQ-027 With SKID_EN=0, in_ready SHALL equal 1 in EMPTY and 0 in MAIN, and SHALL rise in the cycle after MAIN drains.
REQ-028 Payload order SHALL be strictly FIFO.
REQ-029 The stage SHALL never drop a payload except on flush.
REQ-030 The stage SHALL never duplicate a payload.
REQ-031 When flush=1, the next state SHALL be EMPTY and out_data SHALL become NOP_PAYLOAD.
REQ-032 Any input handshake in a flush cycle SHALL count as consumed and be discarded.
REQ-033 An output handshake in a flush cycle SHALL still count as completed.
REQ-034 flush SHALL take priority over every simultaneous event.
REQ-035 flush_cnt SHALL increment by 1 per flush cycle and saturate at all-ones; it SHALL not wrap.
REQ-036 In any state other than EMPTY, out_data SHALL equal the head entry and SHALL remain stable while out_valid & !out_ready.

Reset
REQ-037 On rst, state SHALL go to EMPTY and occupancy to 0.
REQ-038 On rst, out_valid SHALL be 0 and out_data SHALL be NOP_PAYLOAD.
REQ-039 On rst, in_ready SHALL be 0 while rst is asserted and SHALL become 1 on the first clk edge after release.
REQ-040 On rst, flush_cnt SHALL be 0 and the skid entry SHALL be NOP_PAYLOAD.
REQ-041 A reset asserted mid-operation SHALL discard all held payloads immediately, without waiting for a clock edge.

Structure
REQ-042 Package pipe_pkg SHALL hold the state enum typedef (EMPTY/MAIN/SKID) and the constant RV_NOP = 32'h00000013 used as the NOP_PAYLOAD default.
REQ-043 The saturating flush counter SHALL be a sub-module, sat_counter, parametrised by CNT_W.
REQ-044 Head and skid storage SHALL be plain flops; no memory macros.

Verification
REQ-045 With DATA_W=32, out_ready=1 and in_data=1,2,3,4 on consecutive cycles, out_data SHALL show 1,2,3,4 one cycle later with no gaps.
REQ-046 With 0xA then 0xB accepted while out_ready=0, the bench SHALL see occupancy=2 and in_ready=0; after raising out_ready it SHALL see 0xA then 0xB, and in_ready=1 after 0xA leaves.
REQ-047 With flush=1 in SKID while in_valid=1 and in_data=0xC, the bench SHALL next see occupancy=0, out_valid=0, out_data=0x00000013, 0xC never emitted and flush_cnt incremented.
REQ-048 With CNT_W=2 and flush held for 5 cycles, flush_cnt SHALL read 1,2,3,3,3.
REQ-049 With rst asserted asynchronously between edges in MAIN, out_valid SHALL fall before the next edge and out_data SHALL become 0x00000013.
REQ-050 With SKID_EN=0 and out_ready toggling 1,0,1,0 under continuous in_valid, the bench SHALL see no payload lost or duplicated and in_ready=0 in every cycle the stage is occupied.
